// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice and a carry
// flip-flop walk the operands LSB-first, one bit per clock, over WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Handshake: start (with a, b, sub) is accepted on a rising edge only while
    // busy=0, i.e. in IDLE or DONE; it is ignored in RUN and never queued. done
    // is a one-cycle pulse marking sum/cout/overflow as new; busy and done are
    // never high together.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, ps, ps_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c, last, load;

    assign fa_s      = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c      = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last      = (cnt == CW'(WIDTH - 1));
    assign dbg_state = state;

    // The new sum bit enters at the MSB so the word is aligned after WIDTH shifts.
    always_comb begin
        ps_nxt            = ps >> 1;
        ps_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at load and seed the carry with sub.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            ps       <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            ps    <= '0;
            cnt   <= '0;
            carry <= sub;
        end else if (state == RUN) begin
            ps    <= ps_nxt;
            carry <= fa_c;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CW'(1);
            if (last) begin
                // carry still holds the carry into the MSB on the final bit
                sum      <= ps_nxt;
                cout     <= fa_c;
                overflow <= carry ^ fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Table-driven bench for serial_adder at WIDTH 1, 8 and 64, plus hand-written
// sequences for ignored start, back-to-back operation and asynchronous reset.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_x, sub_x;
    logic [63:0] ax, bx;
    int          sel;

    logic        busy1, done1, cout1, ov1;
    logic [0:0]  s1;
    logic [1:0]  st1;
    logic        busy8, done8, cout8, ov8;
    logic [7:0]  s8;
    logic [1:0]  st8;
    logic        busy64, done64, cout64, ov64;
    logic [63:0] s64;
    logic [1:0]  st64;

    logic        o_busy, o_done, o_cout, o_ov;
    logic [63:0] o_sum;
    logic [1:0]  o_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_x && sel == 0), .sub(sub_x),
        .a(ax[0:0]), .b(bx[0:0]), .busy(busy1), .done(done1), .sum(s1),
        .cout(cout1), .overflow(ov1), .dbg_state(st1)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start_x && sel == 1), .sub(sub_x),
        .a(ax[7:0]), .b(bx[7:0]), .busy(busy8), .done(done8), .sum(s8),
        .cout(cout8), .overflow(ov8), .dbg_state(st8)
    );

    serial_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start_x && sel == 2), .sub(sub_x),
        .a(ax), .b(bx), .busy(busy64), .done(done64), .sum(s64),
        .cout(cout64), .overflow(ov64), .dbg_state(st64)
    );

    always_comb begin
        case (sel)
            0: begin
                {o_busy, o_done, o_cout, o_ov} = {busy1, done1, cout1, ov1};
                o_sum   = {63'b0, s1};
                o_state = st1;
            end
            1: begin
                {o_busy, o_done, o_cout, o_ov} = {busy8, done8, cout8, ov8};
                o_sum   = {56'b0, s8};
                o_state = st8;
            end
            default: begin
                {o_busy, o_done, o_cout, o_ov} = {busy64, done64, cout64, ov64};
                o_sum   = s64;
                o_state = st64;
            end
        endcase
    end

    typedef struct {
        int          s;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input bit ok, input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: returns {overflow, cout, sum}.
    function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic sv);
        logic [63:0] m, aa, bb, s;
        logic [64:0] f;
        logic        c, ov;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa = av & m;
        bb = (sv ? ~bv : bv) & m;
        f  = {1'b0, aa} + {1'b0, bb} + {64'b0, sv};
        s  = f[63:0] & m;
        c  = f[w];
        ov = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, c, s};
    endfunction

    task automatic wait_done(input int c0, output int c, output int nbusy, output bit both);
        c     = c0;
        nbusy = 0;
        both  = 1'b0;
        while (!o_done && c < 200) begin
            if (o_busy) nbusy++;
            @(negedge clk);
            c++;
        end
        if (o_busy && o_done) both = 1'b1;
    endtask

    task automatic run_op(input int s, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, input logic [63:0] es, input logic ec,
                          input logic eo, input string nm);
        int w, c, nb;
        bit both;
        w = (s == 0) ? 1 : (s == 1) ? 8 : 64;
        @(negedge clk);
        sel = s; ax = av; bx = bv; sub_x = sv; start_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_x = 1'b0;
        wait_done(1, c, nb, both);
        check(c == w + 1, {nm, " latency"}, 64'(c), 64'(w + 1));
        check(nb == w, {nm, " busy cycles"}, 64'(nb), 64'(w));
        check(!both, {nm, " busy with done"}, 64'(both), 64'd0);
        check({o_ov, o_cout, o_sum} == {eo, ec, es}, {nm, " result"},
              {o_ov, o_cout, o_sum[61:0]}, {eo, ec, es[61:0]});
        @(negedge clk);
        check(!o_done, {nm, " done pulse width"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int c, nb;
        bit both;
        logic [65:0] r;
        logic [63:0] ra, rb;
        logic        rs;

        reset = 1'b1; start_x = 1'b0; sub_x = 1'b0; ax = '0; bx = '0; sel = 1;

        // WIDTH=8 vectors
        vecs.push_back('{1, 64'd100,  64'd27,  1'b0, 64'd127,  1'b0, 1'b0});
        vecs.push_back('{1, 64'd200,  64'd100, 1'b0, 64'h2C,   1'b1, 1'b0});
        vecs.push_back('{1, 64'd127,  64'd1,   1'b0, 64'h80,   1'b0, 1'b1});
        vecs.push_back('{1, 64'd5,    64'd7,   1'b1, 64'hFE,   1'b0, 1'b0});
        vecs.push_back('{1, 64'h80,   64'd1,   1'b1, 64'h7F,   1'b1, 1'b1});
        vecs.push_back('{1, 64'd0,    64'd0,   1'b1, 64'h00,   1'b1, 1'b0});
        vecs.push_back('{1, 64'hFF,   64'h01,  1'b0, 64'h00,   1'b1, 1'b0});
        vecs.push_back('{1, 64'h80,   64'h80,  1'b0, 64'h00,   1'b1, 1'b1});
        // WIDTH=1: every combination
        vecs.push_back('{0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0});
        vecs.push_back('{0, 64'd0, 64'd1, 1'b0, 64'd1, 1'b0, 1'b0});
        vecs.push_back('{0, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0, 1'b0});
        vecs.push_back('{0, 64'd1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b1});
        vecs.push_back('{0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0});
        vecs.push_back('{0, 64'd0, 64'd1, 1'b1, 64'd1, 1'b0, 1'b1});
        vecs.push_back('{0, 64'd1, 64'd0, 1'b1, 64'd1, 1'b1, 1'b0});
        vecs.push_back('{0, 64'd1, 64'd1, 1'b1, 64'd0, 1'b1, 1'b0});
        // WIDTH=64 boundaries
        vecs.push_back('{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0});
        vecs.push_back('{2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                         64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vecs.push_back('{2, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{2, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check({o_busy, o_done, o_cout, o_ov, o_sum, o_state} == '0, "reset values",
                  {o_busy, o_done, o_cout, o_ov, o_sum[59:0]}, 64'd0);
        end
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].es, vecs[i].ec, vecs[i].eo, $sformatf("vec%0d", i));

        // start during RUN is ignored and not queued
        @(negedge clk);
        sel = 1; ax = 3; bx = 4; sub_x = 1'b0; start_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_x = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ax = 9; bx = 9; start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        wait_done(4, c, nb, both);
        check(c == 9, "ignore latency", 64'(c), 64'd9);
        check(o_sum == 64'd7, "ignore sum", o_sum, 64'd7);
        @(negedge clk);
        check(!o_busy && !o_done, "ignore not queued", {o_busy, o_done}, 64'd0);

        // start held high: accepted again in DONE
        @(negedge clk);
        ax = 10; bx = 20; start_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ax = 50; bx = 60;
        wait_done(1, c, nb, both);
        check(c == 9, "b2b first latency", 64'(c), 64'd9);
        check(o_sum == 64'd30, "b2b first sum", o_sum, 64'd30);
        @(posedge clk);
        @(negedge clk);
        start_x = 1'b0;
        check(o_busy == 1'b1, "b2b reaccept", 64'(o_busy), 64'd1);
        wait_done(1, c, nb, both);
        check(c == 9, "b2b second latency", 64'(c), 64'd9);
        check(o_sum == 64'd110, "b2b second sum", o_sum, 64'd110);
        @(negedge clk);
        check(!o_busy && !o_done, "b2b back to idle", {o_busy, o_done}, 64'd0);

        // asynchronous reset mid-RUN clears held results
        @(negedge clk);
        ax = 8'h55; bx = 8'h11; start_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_x = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check({o_busy, o_done, o_cout, o_ov, o_sum} == '0, "async reset clears",
              {o_busy, o_done, o_cout, o_ov, o_sum[59:0]}, 64'd0);
        reset = 1'b0;
        c = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_done || o_busy) c++;
        end
        check(c == 0, "no done after reset", 64'(c), 64'd0);
        run_op(1, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, "post reset 1+1");

        // random operands against the reference arithmetic
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom_range(0, 1));
            r  = model(1, ra, rb, rs);
            run_op(0, ra, rb, rs, r[63:0], r[64], r[65], "w1 random");
        end
        for (int i = 0; i < 800; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom_range(0, 1));
            r  = model(64, ra, rb, rs);
            run_op(2, ra, rb, rs, r[63:0], r[64], r[65], "w64 random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
